// File: rtl/wb_ram_burst_slave.sv
// ---------------------------------------------------------------------------
// wb_ram_burst_slave
//
// Wishbone B4 slave RAM with programmable wait states and registered-feedback
// incrementing bursts (CTI 010 continues, CTI 111 ends). Serves as on-chip
// scratch/program memory behind the SoC interconnect.
//
// Parameters
//   DW          data width (multiple of 8), SW = DW/8 byte lanes
//   AW          word address width
//   DEPTH       words of storage (power of 2, <= 2**AW)
//   WAIT_STATES idle cycles before the first ack of a cycle/burst (0..15)
//
// Ports
//   clk, rst        clock (posedge) and asynchronous active-high reset
//   cyc_i, stb_i    bus cycle valid / beat request
//   we_i            1 = write, 0 = read
//   adr_i [AW]      word address
//   sel_i [SW]      byte-lane enables
//   cti_i [3]       cycle type identifier
//   dat_i [DW]      write data
//   dat_o [DW]      read data, zero unless ack_o is high
//   ack_o           beat acknowledge
//   err_o           error acknowledge
//
// Build option
//   WB_RAM_ERR_EN   when defined, beats whose pointer lies at or above DEPTH
//                   are answered with err_o instead of ack_o and never write.
//                   When undefined, err_o is tied low and accesses alias
//                   modulo DEPTH.
// ---------------------------------------------------------------------------
module wb_ram_burst_slave #(
  parameter int DW          = 32,
  parameter int AW          = 10,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cyc_i,
  input  logic            stb_i,
  input  logic            we_i,
  input  logic [AW-1:0]   adr_i,
  input  logic [DW/8-1:0] sel_i,
  input  logic [2:0]      cti_i,
  input  logic [DW-1:0]   dat_i,
  output logic [DW-1:0]   dat_o,
  output logic            ack_o,
  output logic            err_o
);

  localparam int SW = DW / 8;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [2:0] CTI_INCR = 3'b010;
  localparam logic [3:0] WS_INIT  = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK,
    ST_BURST
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] ptr_q, ptr_d;

  logic          beat;
  logic          out_of_range;
  logic          wr_en;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;
  logic [DW-1:0] rd_data;

  // A beat completes whenever the FSM is in an acknowledging state and the
  // master is still requesting; dropping cyc_i suppresses the beat at once.
  assign beat = cyc_i && stb_i && ((state_q == ST_ACK) || (state_q == ST_BURST));

`ifdef WB_RAM_ERR_EN
  assign out_of_range = (ptr_q > AW'(DEPTH - 1));
`else
  assign out_of_range = 1'b0;
`endif

  assign ack_o = beat && !out_of_range;
  assign err_o = beat && out_of_range;
  assign wr_en = ack_o && we_i;
  assign dat_o = ack_o ? rd_data : '0;

  assign wr_idx = ptr_q[IW-1:0];
  // The RAM is read at the pointer the FSM will hold next cycle, so the
  // registered read data lines up with the beat that uses it.
  assign rd_idx = ptr_d[IW-1:0];

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;

    if (!cyc_i) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (stb_i) begin
            ptr_d = adr_i;
            if (WAIT_STATES == 0) begin
              state_d = ST_ACK;
            end else begin
              state_d = ST_WAIT;
              cnt_d   = WS_INIT;
            end
          end
        end

        // The counter runs regardless of stb_i; the last wait cycle hands
        // over to ACK so the first ack follows WAIT_STATES idle cycles.
        ST_WAIT: begin
          if (cnt_q <= 4'd1) begin
            state_d = ST_ACK;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end

        // Only an incrementing-burst tag keeps the cycle open; end-of-burst
        // and every classic/reserved type close it after this beat.
        ST_ACK, ST_BURST: begin
          if (stb_i) begin
            if (cti_i == CTI_INCR) begin
              state_d = ST_BURST;
              ptr_d   = ptr_q + 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Storage: one byte-wide RAM per lane so each lane's write enable maps
  // directly onto a block-RAM byte enable.
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < SW; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];
      logic [7:0] rd_byte_q;

      always_ff @(posedge clk) begin
        if (wr_en && sel_i[gi]) begin
          lane_mem[wr_idx] <= dat_i[gi*8 +: 8];
        end
        rd_byte_q <= lane_mem[rd_idx];
      end

      assign rd_data[gi*8 +: 8] = rd_byte_q;
    end
  endgenerate

endmodule

// File: tb/tb_wb_ram_burst_slave.sv
module tb_wb_ram_burst_slave;

  localparam int DW    = 32;
  localparam int AW    = 10;
  localparam int DEPTH = 256;
  localparam int WS    = 1;

  localparam int BRK_NONE  = 0;
  localparam int BRK_STALL = 1;
  localparam int BRK_ABORT = 2;
  localparam int BRK_RESET = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          cyc_i, stb_i, we_i;
  logic [AW-1:0] adr_i;
  logic [3:0]    sel_i;
  logic [2:0]    cti_i;
  logic [DW-1:0] dat_i;
  logic [DW-1:0] dat_o;
  logic          ack_o, err_o;

  always #5 clk = ~clk;

  wb_ram_burst_slave #(
    .DW(DW), .AW(AW), .DEPTH(DEPTH), .WAIT_STATES(WS)
  ) dut (
    .clk(clk), .rst(rst), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i),
    .adr_i(adr_i), .sel_i(sel_i), .cti_i(cti_i), .dat_i(dat_i),
    .dat_o(dat_o), .ack_o(ack_o), .err_o(err_o)
  );

  typedef struct packed {
    logic        is_err;
    logic [31:0] data;
    logic [31:0] mask;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          total = 0;
  int          bad   = 0;

  // Reference memory: word contents plus which byte lanes hold known data.
  logic [31:0] m_mem   [DEPTH];
  logic [3:0]  m_known [DEPTH];

  logic [31:0] beat_dat [16];
  logic [3:0]  beat_sel [16];
  logic [2:0]  cti_tbl  [7];

  function automatic logic [31:0] lane_mask(input logic [3:0] s);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) if (s[i]) m[i*8 +: 8] = 8'hFF;
    return m;
  endfunction

  task automatic model_beat(input logic we, input logic [9:0] a,
                            input logic [31:0] d, input logic [3:0] s);
    exp_t        e;
    int          idx;
    logic [31:0] m;
    idx      = int'(a) % DEPTH;
    e.is_err = 1'b0;
    e.data   = '0;
    e.mask   = '0;
`ifdef WB_RAM_ERR_EN
    if (a >= 10'(DEPTH)) e.is_err = 1'b1;
`endif
    if (e.is_err) begin
      e.mask = '1;
    end else if (we) begin
      m            = lane_mask(s);
      m_mem[idx]   = (m_mem[idx] & ~m) | (d & m);
      m_known[idx] = m_known[idx] | s;
    end else begin
      e.data = m_mem[idx];
      e.mask = lane_mask(m_known[idx]);
    end
    sb.push_back(e);
  endtask

  // Monitor: every acknowledged beat is matched against the scoreboard;
  // idle cycles must show zero read data.
  always @(negedge clk) begin
    if (!rst) begin
      total++;
      if (ack_o || err_o) begin
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_ack: ack=%0b err=%0b dat=%08h, none required", ack_o, err_o, dat_o);
        end else begin
          mon_e = sb.pop_front();
          if ((ack_o && err_o) || (err_o != mon_e.is_err) ||
              (((dat_o ^ mon_e.data) & mon_e.mask) != 32'd0)) begin
            bad++;
            $display("FAIL beat: ack=%0b err=%0b dat=%08h required err=%0b dat=%08h mask=%08h",
                     ack_o, err_o, dat_o, mon_e.is_err, mon_e.data, mon_e.mask);
          end
        end
      end else if (dat_o != 32'd0) begin
        bad++;
        $display("FAIL idle_dat: dat=%08h required 00000000", dat_o);
      end
    end
  end

  // Issue one cycle of len beats; optional stall/abort/reset after beat brk_after.
  task automatic run_txn(input logic we, input int len, input logic [9:0] adr,
                         input logic [2:0] single_cti, input int brk_after, input int brk_kind);
    int   n;
    int   exp_n;
    logic got;
    for (int b = 0; b < len; b++) begin
      cyc_i = 1'b1;
      stb_i = 1'b1;
      we_i  = we;
      adr_i = adr + 10'(b);
      dat_i = beat_dat[b];
      sel_i = beat_sel[b];
      cti_i = (len == 1) ? single_cti : ((b == len - 1) ? 3'b111 : 3'b010);
      model_beat(we, adr_i, dat_i, sel_i);
      exp_n = (b == 0) ? WS + 2 : 1;
      n   = 0;
      got = 1'b0;
      while (!got && n < 20) begin
        @(negedge clk);
        n++;
        got = ack_o || err_o;
      end
      total++;
      if (!got) begin
        bad++;
        $display("FAIL timeout: adr=%03h beat=%0d no ack within %0d cycles", adr_i, b, n);
        sb.delete(sb.size() - 1);
        cyc_i = 1'b0;
        stb_i = 1'b0;
        @(posedge clk); #1;
        return;
      end else if (n != exp_n) begin
        bad++;
        $display("FAIL latency: adr=%03h beat=%0d cycles=%0d required=%0d", adr_i, b, n, exp_n);
      end
      $display("beat we=%0b adr=%03h cti=%03b dat_i=%08h sel=%04b dat_o=%08h ack=%0b err=%0b",
               we_i, adr_i, cti_i, dat_i, sel_i, dat_o, ack_o, err_o);
      @(posedge clk); #1;
      if (b == brk_after) begin
        if (brk_kind == BRK_STALL) begin
          stb_i = 1'b0;
          repeat (2) @(posedge clk);
          #1;
        end else if (brk_kind == BRK_ABORT) begin
          cyc_i = 1'b0;
          stb_i = 1'b1;
          we_i  = 1'b1;
          dat_i = 32'hBAD0BAD0;
          repeat (2) @(posedge clk);
          #1;
          stb_i = 1'b0;
          return;
        end else if (brk_kind == BRK_RESET) begin
          rst = 1'b1;
          #1;
          total++;
          if (ack_o || err_o) begin
            bad++;
            $display("FAIL reset_mid_burst: ack=%0b err=%0b required 0 0", ack_o, err_o);
          end
          @(posedge clk); #1;
          rst   = 1'b0;
          cyc_i = 1'b0;
          stb_i = 1'b0;
          @(posedge clk); #1;
          return;
        end
      end
    end
  endtask

  task automatic fill(input int len, input logic [31:0] base);
    for (int i = 0; i < len; i++) begin
      beat_dat[i] = base + 32'(i);
      beat_sel[i] = 4'hF;
    end
  endtask

  function automatic logic [9:0] pick_adr();
    case ($urandom_range(0, 3))
      0:       return 10'($urandom_range(0, 15));
      1:       return 10'($urandom_range(248, 263));
      2:       return 10'($urandom_range(1016, 1023));
      default: return 10'($urandom_range(0, 1023));
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, brk_at, kind;
    cti_tbl = '{3'b000, 3'b001, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]   = '0;
      m_known[i] = 4'h0;
    end
    rst = 1'b1; cyc_i = 0; stb_i = 0; we_i = 0; adr_i = '0;
    sel_i = '0; cti_i = '0; dat_i = '0;
    repeat (2) @(posedge clk);
    #1;
    total += 3;
    if (ack_o !== 1'b0) begin bad++; $display("FAIL reset_ack: got=%0b required=0", ack_o); end
    if (err_o !== 1'b0) begin bad++; $display("FAIL reset_err: got=%0b required=0", err_o); end
    if (dat_o !== 32'd0) begin bad++; $display("FAIL reset_dat: got=%08h required=0", dat_o); end
    rst = 1'b0;
    @(posedge clk); #1;

    // Classic write/read and partial-lane write.
    beat_dat[0] = 32'hDEADBEEF; beat_sel[0] = 4'hF;
    run_txn(1'b1, 1, 10'h004, 3'b000, -1, BRK_NONE);
    run_txn(1'b0, 1, 10'h004, 3'b000, -1, BRK_NONE);
    beat_dat[0] = 32'h0000AA00; beat_sel[0] = 4'b0010;
    run_txn(1'b1, 1, 10'h004, 3'b000, -1, BRK_NONE);
    run_txn(1'b0, 1, 10'h004, 3'b000, -1, BRK_NONE);

    // Burst across the address wrap, then read back.
    fill(4, 32'd1);
    run_txn(1'b1, 4, 10'h3FE, 3'b000, -1, BRK_NONE);
    run_txn(1'b0, 4, 10'h3FE, 3'b000, -1, BRK_NONE);

    // Burst with a 2-cycle strobe gap after beat 2.
    fill(4, 32'h1000);
    run_txn(1'b1, 4, 10'h010, 3'b000, 1, BRK_STALL);
    run_txn(1'b0, 4, 10'h010, 3'b000, 1, BRK_STALL);

    // cyc_i dropped mid-burst: the un-acked words must keep old contents.
    fill(4, 32'h2000);
    run_txn(1'b1, 4, 10'h020, 3'b000, -1, BRK_NONE);
    fill(4, 32'h2F00);
    run_txn(1'b1, 4, 10'h020, 3'b000, 1, BRK_ABORT);
    run_txn(1'b0, 4, 10'h020, 3'b000, -1, BRK_NONE);

    // Reset during a burst: memory contents survive.
    fill(4, 32'h3000);
    run_txn(1'b1, 4, 10'h030, 3'b000, -1, BRK_NONE);
    fill(4, 32'h3F00);
    run_txn(1'b1, 4, 10'h030, 3'b000, 1, BRK_RESET);
    run_txn(1'b0, 4, 10'h030, 3'b000, -1, BRK_NONE);

    // Address at DEPTH: error response or alias of word 0.
    run_txn(1'b0, 1, 10'h100, 3'b000, -1, BRK_NONE);

    // Randomized traffic.
    for (int t = 0; t < 150; t++) begin
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        beat_dat[i] = $urandom;
        beat_sel[i] = 4'($urandom_range(0, 15));
      end
      brk_at = -1;
      kind   = BRK_NONE;
      if (len >= 3 && $urandom_range(0, 4) == 0) begin
        brk_at = $urandom_range(0, len - 2);
        kind   = BRK_STALL;
      end
      run_txn(1'($urandom_range(0, 1)), len, pick_adr(),
              cti_tbl[$urandom_range(0, 6)], brk_at, kind);
      if ($urandom_range(0, 1) == 1) begin
        cyc_i = 1'b0;
        stb_i = 1'b0;
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
    end

    cyc_i = 1'b0;
    stb_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: pending=%0d required=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
